mem_access_ctrl: RTL

- Sequences every CPU memory transaction requested by the control unit's MFA/R/W/MAS signals onto a byte-wide synchronous RAM port.
- Splits byte, halfword and word accesses into little-endian byte cycles, inserts programmable wait states and reports completion on MFC.
- Sits between the control unit and datapath (MAR/MDR) on one side and the RAM on the other.

---
 rtl/mem_access_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs CPU memory transactions (byte/halfword/word) on a
// byte-wide synchronous RAM port. Each transaction becomes little-endian
// byte cycles, and each byte cycle is held for WAIT_CYCLES+1 clocks.
// Completion is reported on mfc. Every output is registered.
//
// Optional feature: define SIGN_EXT_EN to add the sext input. When it is
// set, byte and halfword reads are sign-extended instead of zero-extended.
//
// Ports:
//   clk, CLR          clock (rising edge), async active-low reset
//   mfa, rw, mas      request level, 1=read/0=write, size (00 B, 01 W, 10 H)
//   addr, din         byte address and write data, captured at acceptance
//   sext              (SIGN_EXT_EN only) sign-extend byte/halfword reads
//   dout              read data, holds its value between transactions
//   mfc, align_err    completion flag, misaligned/reserved-size flag
//   busy              high whenever the FSM is not in IDLE
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata  byte-wide RAM port
module mem_access_ctrl #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              mfa,
  input  logic              rw,
  input  logic [1:0]        mas,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
`ifdef SIGN_EXT_EN
  input  logic              sext,
`endif
  output logic [31:0]       dout,
  output logic              mfc,
  output logic              align_err,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int unsigned WAIT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic [1:0]          last_q, last_d;      // index of the final byte (N-1)
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          idx_n_c;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                sext_q, sext_d;
  logic [31:0]         dout_q, dout_d;
  logic                mfc_q, mfc_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic                misalign_c;
  logic [1:0]          last_c;

  // Reserved size always fails; halfword/word need natural alignment.
  always_comb begin
    misalign_c = 1'b0;
    last_c     = 2'd0;
    case (mas)
      2'b00: last_c = 2'd0;
      2'b01: begin last_c = 2'd3; misalign_c = (addr[1:0] != 2'b00); end
      2'b10: begin last_c = 2'd1; misalign_c = addr[0]; end
      default: misalign_c = 1'b1;
    endcase
  end

  assign idx_n_c = idx_q + 2'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    last_d      = last_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    din_d       = din_q;
    sext_d      = sext_q;
    dout_d      = dout_q;
    mfc_d       = mfc_q;
    err_d       = err_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      IDLE: begin
        if (mfa) begin
          rw_d   = rw;
          last_d = last_c;
          addr_d = addr;
          din_d  = din;
`ifdef SIGN_EXT_EN
          sext_d = sext;
`else
          sext_d = 1'b0;
`endif
          if (misalign_c) begin
            state_d = DONE;
            mfc_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ACCESS;
            idx_d       = 2'd0;
            wcnt_d      = '0;
            err_d       = 1'b0;
            ram_en_d    = 1'b1;
            ram_we_d    = ~rw;
            ram_addr_d  = addr;
            ram_wdata_d = din[7:0];
            if (rw) dout_d = 32'h0;
          end
        end
      end

      ACCESS: begin
        if (wcnt_q == WAIT_W'(WAIT_CYCLES)) begin
          // Last cycle of this byte: ram_rdata is valid now.
          wcnt_d = '0;
          if (rw_q) dout_d[{idx_q, 3'b000} +: 8] = ram_rdata;
          if (idx_q == last_q) begin
            state_d  = DONE;
            mfc_d    = 1'b1;
            ram_en_d = 1'b0;
            ram_we_d = 1'b0;
`ifdef SIGN_EXT_EN
            // The final byte of a read is the most significant, so its
            // top bit is the sign.
            if (rw_q && sext_q) begin
              if (last_q == 2'd0)      dout_d[31:8]  = {24{ram_rdata[7]}};
              else if (last_q == 2'd1) dout_d[31:16] = {16{ram_rdata[7]}};
            end
`endif
          end else begin
            idx_d       = idx_n_c;
            ram_addr_d  = addr_q + ADDR_W'(idx_n_c);
            ram_wdata_d = din_q[{idx_n_c, 3'b000} +: 8];
          end
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end

      DONE: begin
        if (!mfa) begin
          state_d = IDLE;
          mfc_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      last_q      <= 2'd0;
      idx_q       <= 2'd0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      din_q       <= 32'h0;
      sext_q      <= 1'b0;
      dout_q      <= 32'h0;
      mfc_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      sext_q      <= sext_d;
      dout_q      <= dout_d;
      mfc_q       <= mfc_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign dout      = dout_q;
  assign mfc       = mfc_q;
  assign align_err = err_q;
  assign busy      = busy_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
